uart_rx_param: RTL and testbench



---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync2.sv | 32 +++
 rtl/uart_rx_param.sv | 206 ++++++++++++++++++++
 tb/tb_uart_rx_param.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants for the UART receiver, transmitter and their benches.
//   - Receiver FSM state encoding (3 bits, fixed values so that existing
//     tools and benches that print raw state values keep working).
//   - Parity sense constants.
// ---------------------------------------------------------------------------
package uart_pkg;

    localparam logic [2:0] ST_IDLE    = 3'd0;  // waiting for a start edge
    localparam logic [2:0] ST_DESFASO = 3'd1;  // half-bit offset to mid start bit
    localparam logic [2:0] ST_ESPERO  = 3'd2;  // wait one bit period
    localparam logic [2:0] ST_RECIBO  = 3'd3;  // sample one data bit
    localparam logic [2:0] ST_PARIDAD = 3'd4;  // sample the parity bit
    localparam logic [2:0] ST_FIN     = 3'd5;  // sample a stop bit

    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/uart_sync2.sv
// ---------------------------------------------------------------------------
// uart_sync2
// Two-flop synchroniser for an asynchronous, idle-high input.
// Ports:
//   clk   in  system clock
//   reset in  synchronous, active-high; both flops reset to 1 (idle level)
//   d     in  asynchronous input
//   q     out synchronised copy of d, two clk of latency
// ---------------------------------------------------------------------------
module uart_sync2 (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b1;
            sync_q <= 1'b1;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_param.sv
// ---------------------------------------------------------------------------
// uart_rx_param
// Oversampled UART receiver: DBIT data bits (LSB first), optional parity,
// one or two stop bits, OVERSAMPLE ticks per bit, samples at mid-bit.
// Ports:
//   clk        in   system clock
//   reset      in   synchronous, active-high
//   tick       in   oversample enable (OVERSAMPLE pulses per bit)
//   rx         in   asynchronous serial line, idle high
//   d_out      out  last received data word
//   rx_done    out  one-clk pulse when a frame completes
//   parity_err out  parity mismatch on the last frame
//   frame_err  out  a stop bit was sampled low on the last frame
//   break_det  out  frame error with all data and parity bits 0
// ---------------------------------------------------------------------------
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DBIT       = 8,
    parameter int OVERSAMPLE = 16,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            tick,
    input  logic            rx,
    output logic [DBIT-1:0] d_out,
    output logic            rx_done,
    output logic            parity_err,
    output logic            frame_err,
    output logic            break_det
);

    localparam int SW = $clog2(OVERSAMPLE);
    localparam int NW = $clog2(DBIT + 1);
    localparam logic [SW-1:0] HALF_LAST = SW'(OVERSAMPLE / 2 - 1);
    // ESPERO spends OVERSAMPLE-1 ticks; the sample state adds the last one.
    localparam logic [SW-1:0] WAIT_LAST = SW'(OVERSAMPLE - 2);
    localparam logic [NW-1:0] N_LAST    = NW'(DBIT);
    localparam logic          PAR_SENSE = (PARITY_ODD != 0) ? PAR_ODD : PAR_EVEN;

    logic rx_s;

    uart_sync2 u_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rx),
        .q     (rx_s)
    );

    logic [2:0]      state_q, state_d;
    logic [SW-1:0]   s_q, s_d;
    logic [NW-1:0]   n_q, n_d;
    logic [DBIT-1:0] buffer_q, buffer_d;
    logic            par_taken_q, par_taken_d;    // parity bit already sampled
    logic            stop_taken_q, stop_taken_d;  // first of two stop bits sampled
    logic            par_err_q, par_err_d;        // in-frame parity result
    logic            frm_err_q, frm_err_d;        // in-frame stop-bit result
    logic            ones_q, ones_d;              // any data/parity bit was 1
    logic [DBIT-1:0] d_out_q, d_out_d;
    logic            rx_done_q, rx_done_d;
    logic            parity_err_q, parity_err_d;
    logic            frame_err_q, frame_err_d;
    logic            break_det_q, break_det_d;
    logic            frm_now;

    always_comb begin
        state_d      = state_q;
        s_d          = s_q;
        n_d          = n_q;
        buffer_d     = buffer_q;
        par_taken_d  = par_taken_q;
        stop_taken_d = stop_taken_q;
        par_err_d    = par_err_q;
        frm_err_d    = frm_err_q;
        ones_d       = ones_q;
        d_out_d      = d_out_q;
        rx_done_d    = 1'b0;
        parity_err_d = parity_err_q;
        frame_err_d  = frame_err_q;
        break_det_d  = break_det_q;
        frm_now      = frm_err_q | ~rx_s;

        case (state_q)
            ST_IDLE: begin
                // Start detection is the only tick-independent transition.
                if (!rx_s) begin
                    state_d = ST_DESFASO;
                    s_d     = '0;
                end
            end
            ST_DESFASO: begin
                if (tick) begin
                    if (s_q == HALF_LAST) begin
                        s_d = '0;
                        if (!rx_s) begin
                            state_d      = ST_ESPERO;
                            n_d          = '0;
                            par_taken_d  = 1'b0;
                            stop_taken_d = 1'b0;
                            par_err_d    = 1'b0;
                            frm_err_d    = 1'b0;
                            ones_d       = 1'b0;
                        end else begin
                            state_d = ST_IDLE;  // glitch, not a start bit
                        end
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_ESPERO: begin
                if (tick) begin
                    if (s_q == WAIT_LAST) begin
                        s_d = '0;
                        if (n_q < N_LAST)
                            state_d = ST_RECIBO;
                        else if ((PARITY_EN != 0) && !par_taken_q)
                            state_d = ST_PARIDAD;
                        else
                            state_d = ST_FIN;
                    end else begin
                        s_d = s_q + SW'(1);
                    end
                end
            end
            ST_RECIBO: begin
                if (tick) begin
                    buffer_d = {rx_s, buffer_q[DBIT-1:1]};
                    n_d      = n_q + NW'(1);
                    ones_d   = ones_q | rx_s;
                    state_d  = ST_ESPERO;
                end
            end
            ST_PARIDAD: begin
                if (tick) begin
                    par_err_d   = rx_s ^ (^buffer_q) ^ PAR_SENSE;
                    par_taken_d = 1'b1;
                    ones_d      = ones_q | rx_s;
                    state_d     = ST_ESPERO;
                end
            end
            ST_FIN: begin
                if (tick) begin
                    if ((STOP_BITS == 2) && !stop_taken_q) begin
                        frm_err_d    = frm_now;
                        stop_taken_d = 1'b1;
                        state_d      = ST_ESPERO;
                    end else begin
                        // Publish the whole frame result in one clk.
                        state_d      = ST_IDLE;
                        rx_done_d    = 1'b1;
                        d_out_d      = buffer_q;
                        parity_err_d = par_err_q;
                        frame_err_d  = frm_now;
                        break_det_d  = frm_now & ~ones_q;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            buffer_q     <= '0;
            par_taken_q  <= 1'b0;
            stop_taken_q <= 1'b0;
            par_err_q    <= 1'b0;
            frm_err_q    <= 1'b0;
            ones_q       <= 1'b0;
            d_out_q      <= '0;
            rx_done_q    <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            break_det_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            buffer_q     <= buffer_d;
            par_taken_q  <= par_taken_d;
            stop_taken_q <= stop_taken_d;
            par_err_q    <= par_err_d;
            frm_err_q    <= frm_err_d;
            ones_q       <= ones_d;
            d_out_q      <= d_out_d;
            rx_done_q    <= rx_done_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            break_det_q  <= break_det_d;
        end
    end

    assign d_out      = d_out_q;
    assign rx_done    = rx_done_q;
    assign parity_err = parity_err_q;
    assign frame_err  = frame_err_q;
    assign break_det  = break_det_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// ---------------------------------------------------------------------------
// tb_uart_rx_param
// Three receiver configurations side by side:
//   A: defaults (8N1, 16x, tick=1)
//   B: 8 data bits, even parity, 16x, tick=1
//   C: 7 data bits, 2 stop bits, 8x, tick every 3rd clk
// ---------------------------------------------------------------------------
module tb_uart_rx_param;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic rst_a, rst_b, rst_c;
    logic rx_a, rx_b, rx_c;
    logic tick_a, tick_b;
    logic tick_c = 1'b0;
    int   tdiv = 0;

    logic [7:0] d_out_a, d_out_b;
    logic [6:0] d_out_c;
    logic rx_done_a, parity_err_a, frame_err_a, break_det_a;
    logic rx_done_b, parity_err_b, frame_err_b, break_det_b;
    logic rx_done_c, parity_err_c, frame_err_c, break_det_c;

    always @(negedge clk) begin
        tdiv   = (tdiv == 2) ? 0 : tdiv + 1;
        tick_c = (tdiv == 0);
    end

    uart_rx_param u_a (
        .clk(clk), .reset(rst_a), .tick(tick_a), .rx(rx_a), .d_out(d_out_a),
        .rx_done(rx_done_a), .parity_err(parity_err_a), .frame_err(frame_err_a),
        .break_det(break_det_a)
    );

    uart_rx_param #(.PARITY_EN(1), .PARITY_ODD(0)) u_b (
        .clk(clk), .reset(rst_b), .tick(tick_b), .rx(rx_b), .d_out(d_out_b),
        .rx_done(rx_done_b), .parity_err(parity_err_b), .frame_err(frame_err_b),
        .break_det(break_det_b)
    );

    uart_rx_param #(.DBIT(7), .OVERSAMPLE(8), .STOP_BITS(2)) u_c (
        .clk(clk), .reset(rst_c), .tick(tick_c), .rx(rx_c), .d_out(d_out_c),
        .rx_done(rx_done_c), .parity_err(parity_err_c), .frame_err(frame_err_c),
        .break_det(break_det_c)
    );

    // {parity_err, frame_err, break_det, data[8:0]} per DUT
    logic [11:0] out_v [3];
    logic [2:0]  done_v;
    assign out_v[0] = {parity_err_a, frame_err_a, break_det_a, 1'b0, d_out_a};
    assign out_v[1] = {parity_err_b, frame_err_b, break_det_b, 1'b0, d_out_b};
    assign out_v[2] = {parity_err_c, frame_err_c, break_det_c, 2'b00, d_out_c};
    assign done_v   = {rx_done_c, rx_done_b, rx_done_a};

    // Monitor: capture outputs at every rx_done, flag pulses longer than 1 clk.
    int          cnt [3] = '{0, 0, 0};
    logic [11:0] cap [3][64];
    int          dcyc [3][64];
    int          long_pulses = 0;
    logic [2:0]  prev_done = 3'b000;

    always @(negedge clk) begin
        for (int k = 0; k < 3; k++) begin
            if (done_v[k]) begin
                cap[k][cnt[k] & 63]  = out_v[k];
                dcyc[k][cnt[k] & 63] = cyc;
                cnt[k]               = cnt[k] + 1;
                if (prev_done[k]) long_pulses = long_pulses + 1;
            end
        end
        prev_done = done_v;
    end

    int checks   = 0;
    int failures = 0;
    int frame_t0 = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic set_rx(input int dut, input logic v);
        case (dut)
            0:       rx_a = v;
            1:       rx_b = v;
            default: rx_c = v;
        endcase
    endtask

    function automatic int cpb_of(input int dut);
        return (dut == 2) ? 24 : 16;
    endfunction

    // Drives one complete frame; called at a negedge, returns at a negedge
    // with the line back at idle.
    task automatic send_frame(input int dut, input logic [8:0] data,
                              input logic par_bit, input logic stop_val);
        int nbits, nstop, cpb;
        nbits = (dut == 2) ? 7 : 8;
        nstop = (dut == 2) ? 2 : 1;
        cpb   = cpb_of(dut);
        frame_t0 = cyc;
        set_rx(dut, 1'b0);
        repeat (cpb) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            set_rx(dut, data[i]);
            repeat (cpb) @(negedge clk);
        end
        if (dut == 1) begin
            set_rx(dut, par_bit);
            repeat (cpb) @(negedge clk);
        end
        for (int i = 0; i < nstop; i++) begin
            set_rx(dut, stop_val);
            repeat (cpb) @(negedge clk);
        end
        set_rx(dut, 1'b1);
    endtask

    typedef struct {
        int         dut;
        logic [8:0] data;
        logic       par_bit;
        logic       stop_val;
        logic [8:0] exp_d;
        logic [2:0] exp_err;   // {parity, frame, break}
    } vec_t;

    vec_t vecs [8];

    initial begin
        int base;
        logic [11:0] prev_out;

        vecs[0] = '{0, 9'h0A5, 1'b0, 1'b1, 9'h0A5, 3'b000};
        vecs[1] = '{0, 9'h03C, 1'b0, 1'b0, 9'h03C, 3'b010};
        vecs[2] = '{0, 9'h000, 1'b0, 1'b1, 9'h000, 3'b000};
        vecs[3] = '{1, 9'h007, 1'b0, 1'b1, 9'h007, 3'b100};
        vecs[4] = '{1, 9'h007, 1'b1, 1'b1, 9'h007, 3'b000};
        vecs[5] = '{1, 9'h05A, 1'b0, 1'b1, 9'h05A, 3'b000};
        vecs[6] = '{1, 9'h000, 1'b0, 1'b0, 9'h000, 3'b011};
        vecs[7] = '{2, 9'h055, 1'b0, 1'b1, 9'h055, 3'b000};

        rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
        rx_a = 1'b1;  rx_b = 1'b1;  rx_c = 1'b1;
        tick_a = 1'b1; tick_b = 1'b1;
        repeat (4) @(negedge clk);
        rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("reset_out%0d", k), 32'(out_v[k]), 32'd0);
        end
        chk("reset_done", 32'(done_v), 32'd0);

        // Table-driven frames
        for (int i = 0; i < 8; i++) begin
            base = cnt[vecs[i].dut];
            send_frame(vecs[i].dut, vecs[i].data, vecs[i].par_bit, vecs[i].stop_val);
            repeat (3 * cpb_of(vecs[i].dut)) @(negedge clk);
            $display("vec %0d dut %0d data 0x%0h -> out 0x%0h dones %0d",
                     i, vecs[i].dut, vecs[i].data, cap[vecs[i].dut][base & 63],
                     cnt[vecs[i].dut] - base);
            chk($sformatf("vec%0d_done_count", i), 32'(cnt[vecs[i].dut]), 32'(base + 1));
            chk($sformatf("vec%0d_d_out", i), 32'(cap[vecs[i].dut][base & 63][8:0]),
                32'(vecs[i].exp_d));
            chk($sformatf("vec%0d_flags", i), 32'(cap[vecs[i].dut][base & 63][11:9]),
                32'(vecs[i].exp_err));
            if (i == 0)
                chk("latency_8n1", 32'(dcyc[0][base & 63] - frame_t0), 32'd155);
        end

        // Glitch: 5 clk low must be rejected as a false start
        base     = cnt[0];
        prev_out = out_v[0];
        rx_a = 1'b0;
        repeat (5) @(negedge clk);
        rx_a = 1'b1;
        repeat (48) @(negedge clk);
        $display("glitch: dones %0d out 0x%0h", cnt[0] - base, out_v[0]);
        chk("glitch_no_done", 32'(cnt[0]), 32'(base));
        chk("glitch_out_held", 32'(out_v[0]), 32'(prev_out));

        // Break: line low for 12 bit times; the trailing low also starts a
        // second frame once FIN has returned the FSM to IDLE.
        base = cnt[0];
        rx_a = 1'b0;
        repeat (12 * 16) @(negedge clk);
        rx_a = 1'b1;
        repeat (25 * 16) @(negedge clk);
        $display("break: first out 0x%0h dones %0d", cap[0][base & 63], cnt[0] - base);
        chk("break_done_count", 32'(cnt[0]), 32'(base + 2));
        chk("break_d_out", 32'(cap[0][base & 63][8:0]), 32'd0);
        chk("break_flags", 32'(cap[0][base & 63][11:9]), 32'b011);

        // Back-to-back frames on C (2 stop bits, tick every 3rd clk)
        base = cnt[2];
        send_frame(2, 9'h055, 1'b0, 1'b1);
        send_frame(2, 9'h02A, 1'b0, 1'b1);
        repeat (72) @(negedge clk);
        $display("b2b: out0 0x%0h out1 0x%0h dones %0d",
                 cap[2][base & 63], cap[2][(base + 1) & 63], cnt[2] - base);
        chk("b2b_done_count", 32'(cnt[2]), 32'(base + 2));
        chk("b2b_first", 32'(cap[2][base & 63]), 32'h055);
        chk("b2b_second", 32'(cap[2][(base + 1) & 63]), 32'h02A);

        // Reset in the middle of data bit 0 on C
        base = cnt[2];
        rx_c = 1'b0;
        repeat (24) @(negedge clk);
        rx_c = 1'b1;
        repeat (12) @(negedge clk);
        rst_c = 1'b1;
        @(negedge clk);
        rst_c = 1'b0;
        $display("mid-frame reset: out 0x%0h", out_v[2]);
        chk("midreset_out", 32'(out_v[2]), 32'd0);
        repeat (300) @(negedge clk);
        chk("midreset_no_done", 32'(cnt[2]), 32'(base));
        send_frame(2, 9'h01B, 1'b0, 1'b1);
        repeat (72) @(negedge clk);
        $display("after reset: out 0x%0h dones %0d", cap[2][base & 63], cnt[2] - base);
        chk("after_reset_count", 32'(cnt[2]), 32'(base + 1));
        chk("after_reset_data", 32'(cap[2][base & 63]), 32'h01B);

        chk("done_pulse_width", 32'(long_pulses), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
